// File: rtl/lb_regbank.sv
// lb_regbank: localbus register bank with NRW read-write config registers, NRO read-only
// status registers and a fixed RDLAT-deep response pipeline. Optional feature: LB_REGBANK_ERRCNT_EN.
module lb_regbank #(
    parameter int                  LBCWIDTH      = 8,
    parameter int                  LBAWIDTH      = 24,
    parameter int                  LBDWIDTH      = 32,
    parameter int                  WRITECMD      = 1,
    parameter int                  READCMD       = 0,
    parameter int                  NRW           = 16,
    parameter int                  NRO           = 8,
    parameter int                  BASE          = 0,
    parameter int                  RDLAT         = 2,
    parameter logic [LBDWIDTH-1:0] DEFAULT_RDATA = 32'hdeadbeef
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      wvalid,
    input  logic [LBCWIDTH-1:0]                       wctrl,
    input  logic [LBAWIDTH-1:0]                       waddr,
    input  logic [LBDWIDTH-1:0]                       wdata,
    output logic                                      rready,
    output logic [LBCWIDTH-1:0]                       rctrl,
    output logic [LBAWIDTH-1:0]                       raddr,
    output logic [LBDWIDTH-1:0]                       rdata,
    output logic [NRW*LBDWIDTH-1:0]                   cfg_q,
    output logic [NRW-1:0]                            cfg_stb,
    input  logic [((NRO > 0) ? NRO : 1)*LBDWIDTH-1:0] sts_i,
    output logic [((NRO > 0) ? NRO : 1)-1:0]          sts_rd_stb
`ifdef LB_REGBANK_ERRCNT_EN
    ,
    output logic [15:0]                               err_cnt
`endif
);

    localparam int NROW = (NRO > 0) ? NRO : 1;
    localparam logic [LBAWIDTH-1:0] BASE_A = LBAWIDTH'(BASE);
    localparam logic [LBAWIDTH-1:0] NRW_A  = LBAWIDTH'(NRW);
    localparam logic [LBAWIDTH-1:0] NRO_A  = LBAWIDTH'(NRO);
    localparam logic [LBCWIDTH-1:0] CMD_WR = LBCWIDTH'(WRITECMD);
    localparam logic [LBCWIDTH-1:0] CMD_RD = LBCWIDTH'(READCMD);

    typedef struct packed {
        logic                valid;
        logic [LBCWIDTH-1:0] ctrl;
        logic [LBAWIDTH-1:0] addr;
        logic [LBDWIDTH-1:0] data;
    } resp_t;

    logic [LBAWIDTH-1:0] offset;
    logic                inWin;
    logic                isWrite;
    logic                isRead;
    logic                rwHit;
    logic                roHit;
    logic [LBDWIDTH-1:0] rdNext;

    logic [LBDWIDTH-1:0] cfgMem_q [NRW];
    logic [NRW-1:0]      cfgStb_d;
    logic [NRW-1:0]      cfgStb_q;
    logic [NROW-1:0]     stsStb_d;
    logic [NROW-1:0]     stsStb_q;
    resp_t               resp_d;
    resp_t               pipe_q [RDLAT];

`ifdef LB_REGBANK_ERRCNT_EN
    logic                ecHit;
    logic                errInc;
    logic                errClr;
    logic [15:0]         errCnt_q;
`endif

    always_comb begin
        offset  = waddr - BASE_A;
        inWin   = (waddr >= BASE_A);
        isWrite = (wctrl == CMD_WR);
        isRead  = (wctrl == CMD_RD);
        rwHit   = inWin && (offset < NRW_A);
        roHit   = inWin && (offset >= NRW_A) && (offset < (NRW_A + NRO_A));
`ifdef LB_REGBANK_ERRCNT_EN
        ecHit   = inWin && (offset == (NRW_A + NRO_A));
        errInc  = wvalid && ((!rwHit && !roHit && !ecHit) || (isWrite && roHit));
        errClr  = wvalid && isWrite && ecHit;
`endif

        // Non-read commands echo the write data back on the response side.
        rdNext = wdata;
        if (isRead) begin
            rdNext = DEFAULT_RDATA;
            for (int i = 0; i < NRW; i++) begin
                if (rwHit && (offset == LBAWIDTH'(i)))
                    rdNext = cfgMem_q[i];
            end
            for (int j = 0; j < NRO; j++) begin
                if (roHit && (offset == (NRW_A + LBAWIDTH'(j))))
                    rdNext = sts_i[j*LBDWIDTH +: LBDWIDTH];
            end
`ifdef LB_REGBANK_ERRCNT_EN
            if (ecHit)
                rdNext = LBDWIDTH'(errCnt_q);
`endif
        end

        cfgStb_d = '0;
        for (int i = 0; i < NRW; i++)
            cfgStb_d[i] = wvalid && isWrite && rwHit && (offset == LBAWIDTH'(i));

        stsStb_d = '0;
        for (int j = 0; j < NRO; j++)
            stsStb_d[j] = wvalid && isRead && roHit && (offset == (NRW_A + LBAWIDTH'(j)));

        resp_d.valid = wvalid;
        resp_d.ctrl  = wctrl;
        resp_d.addr  = waddr;
        resp_d.data  = rdNext;
    end

    // Reset also flushes the response pipeline so in-flight transactions never surface.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NRW; i++)
                cfgMem_q[i] <= '0;
            cfgStb_q <= '0;
            stsStb_q <= '0;
            for (int s = 0; s < RDLAT; s++)
                pipe_q[s] <= '0;
        end else begin
            for (int i = 0; i < NRW; i++) begin
                if (cfgStb_d[i])
                    cfgMem_q[i] <= wdata;
            end
            cfgStb_q  <= cfgStb_d;
            stsStb_q  <= stsStb_d;
            pipe_q[0] <= resp_d;
            for (int s = 1; s < RDLAT; s++)
                pipe_q[s] <= pipe_q[s-1];
        end
    end

`ifdef LB_REGBANK_ERRCNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            errCnt_q <= '0;
        else if (errClr)
            errCnt_q <= '0;
        else if (errInc && (errCnt_q != 16'hffff))
            errCnt_q <= errCnt_q + 16'd1;
    end

    assign err_cnt = errCnt_q;
`endif

    for (genvar g = 0; g < NRW; g++) begin : gCfgPack
        assign cfg_q[g*LBDWIDTH +: LBDWIDTH] = cfgMem_q[g];
    end

    assign cfg_stb    = cfgStb_q;
    assign sts_rd_stb = stsStb_q;
    assign rready     = pipe_q[RDLAT-1].valid;
    assign rctrl      = pipe_q[RDLAT-1].ctrl;
    assign raddr      = pipe_q[RDLAT-1].addr;
    assign rdata      = pipe_q[RDLAT-1].data;

endmodule

// File: tb/tb_lb_regbank.sv
// tb_lb_regbank: directed bench driving three lb_regbank copies (RDLAT 1, 2, 4) from one
// shared request stream; the RDLAT=2 copy carries the single-transaction checks.
module tb_lb_regbank;

    localparam int DW  = 32;
    localparam int AW  = 24;
    localparam int CW  = 8;
    localparam int NRW = 16;
    localparam int NRO = 8;
    localparam int NB2B = 20;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          wvalid = 1'b0;
    logic [CW-1:0] wctrl  = '0;
    logic [AW-1:0] waddr  = '0;
    logic [DW-1:0] wdata  = '0;
    logic [NRO*DW-1:0] stsIn = '0;

    logic              rreadyA [3];
    logic [CW-1:0]     rctrlA  [3];
    logic [AW-1:0]     raddrA  [3];
    logic [DW-1:0]     rdataA  [3];
    logic [NRW*DW-1:0] cfgA    [3];
    logic [NRW-1:0]    cfgStbA [3];
    logic [NRO-1:0]    stsStbA [3];
`ifdef LB_REGBANK_ERRCNT_EN
    logic [15:0]       errCntA [3];
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [AW-1:0] expAddr [NB2B];
    logic [DW-1:0] expData [NB2B];
    logic [CW-1:0] expCtrl [NB2B];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        lb_regbank #(
            .RDLAT((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) dut (
            .clk        (clk),
            .rstn       (rstn),
            .wvalid     (wvalid),
            .wctrl      (wctrl),
            .waddr      (waddr),
            .wdata      (wdata),
            .rready     (rreadyA[g]),
            .rctrl      (rctrlA[g]),
            .raddr      (raddrA[g]),
            .rdata      (rdataA[g]),
            .cfg_q      (cfgA[g]),
            .cfg_stb    (cfgStbA[g]),
            .sts_i      (stsIn),
            .sts_rd_stb (stsStbA[g])
`ifdef LB_REGBANK_ERRCNT_EN
            ,
            .err_cnt    (errCntA[g])
`endif
        );
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wvalid = v;
        wctrl  = c;
        waddr  = a;
        wdata  = d;
    endtask

    // Outputs are read 1 time unit after the rising edge, away from the sampling instant.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int n = 0; n < NB2B; n++) begin
            if (n % 2 == 0) begin
                expCtrl[n] = 8'd1;
                expAddr[n] = AW'((n / 2) % 8);
            end else begin
                expCtrl[n] = 8'd0;
                expAddr[n] = AW'(((n - 1) / 2) % 8);
            end
            expData[n] = 32'h1000_0000 + DW'(n - (n % 2));
        end

        tick();
        tick();
        checkOutput("reset rready", 64'(rreadyA[1]), 64'd0);
        checkOutput("reset rdata", 64'(rdataA[1]), 64'd0);
        checkOutput("reset cfg_q", 64'(cfgA[1] != '0), 64'd0);
        checkOutput("reset cfg_stb", 64'(cfgStbA[1]), 64'd0);
        checkOutput("reset sts_rd_stb", 64'(stsStbA[1]), 64'd0);
        rstn = 1'b1;

        applyStimulus(1'b1, 8'd1, 24'd3, 32'h12345678);
        tick();
        applyStimulus(1'b0, 8'd0, 24'd0, 32'd0);
        checkOutput("wr3 cfg_stb", 64'(cfgStbA[1]), 64'h0008);
        checkOutput("wr3 cfg_q", 64'(cfgA[1][3*DW +: DW]), 64'h12345678);
        checkOutput("wr3 early rready", 64'(rreadyA[1]), 64'd0);
        tick();
        checkOutput("wr3 cfg_stb off", 64'(cfgStbA[1]), 64'd0);
        checkOutput("wr3 rready", 64'(rreadyA[1]), 64'd1);
        checkOutput("wr3 rdata", 64'(rdataA[1]), 64'h12345678);
        checkOutput("wr3 raddr", 64'(raddrA[1]), 64'd3);
        checkOutput("wr3 rctrl", 64'(rctrlA[1]), 64'd1);
        tick();
        checkOutput("wr3 rready off", 64'(rreadyA[1]), 64'd0);

        applyStimulus(1'b1, 8'd1, 24'd5, 32'hA5A5A5A5);
        tick();
        applyStimulus(1'b1, 8'd0, 24'd5, 32'h0);
        tick();
        applyStimulus(1'b0, 8'd0, 24'd0, 32'd0);
        checkOutput("wr5 rready", 64'(rreadyA[1]), 64'd1);
        checkOutput("wr5 rctrl", 64'(rctrlA[1]), 64'd1);
        tick();
        checkOutput("rd5 rready", 64'(rreadyA[1]), 64'd1);
        checkOutput("rd5 rctrl", 64'(rctrlA[1]), 64'd0);
        checkOutput("rd5 rdata", 64'(rdataA[1]), 64'hA5A5A5A5);
        tick();
        checkOutput("rd5 rready off", 64'(rreadyA[1]), 64'd0);

        stsIn[2*DW +: DW] = 32'hCAFE0002;
        applyStimulus(1'b1, 8'd0, 24'(NRW + 2), 32'h0);
        tick();
        applyStimulus(1'b0, 8'd0, 24'd0, 32'd0);
        stsIn[2*DW +: DW] = 32'h0;
        checkOutput("sts2 strobe", 64'(stsStbA[1]), 64'h04);
        checkOutput("sts2 cfg_stb", 64'(cfgStbA[1]), 64'd0);
        tick();
        checkOutput("sts2 strobe off", 64'(stsStbA[1]), 64'd0);
        checkOutput("sts2 rready", 64'(rreadyA[1]), 64'd1);
        checkOutput("sts2 rdata", 64'(rdataA[1]), 64'hCAFE0002);
        checkOutput("sts2 raddr", 64'(raddrA[1]), 64'(NRW + 2));
        tick();

        applyStimulus(1'b1, 8'd0, 24'(NRW + NRO + 1), 32'h0);
        tick();
        applyStimulus(1'b0, 8'd0, 24'd0, 32'd0);
        checkOutput("unmap cfg_stb", 64'(cfgStbA[1]), 64'd0);
        checkOutput("unmap sts_rd_stb", 64'(stsStbA[1]), 64'd0);
`ifdef LB_REGBANK_ERRCNT_EN
        checkOutput("unmap err_cnt", 64'(errCntA[1]), 64'd1);
`endif
        tick();
        checkOutput("unmap rready", 64'(rreadyA[1]), 64'd1);
        checkOutput("unmap rdata", 64'(rdataA[1]), 64'hdeadbeef);
`ifdef LB_REGBANK_ERRCNT_EN
        applyStimulus(1'b1, 8'd1, 24'(NRW + NRO), 32'h5);
        tick();
        applyStimulus(1'b0, 8'd0, 24'd0, 32'd0);
        checkOutput("errcnt clear", 64'(errCntA[1]), 64'd0);
`endif
        tick();
        tick();
        tick();

        // Request n is accepted at edge n; a copy with latency L shows it after edge n+L-1.
        for (int m = 0; m < NB2B + 4; m++) begin
            if (m < NB2B)
                applyStimulus(1'b1, expCtrl[m], expAddr[m], (m % 2 == 0) ? expData[m] : 32'h0);
            else
                applyStimulus(1'b0, 8'd0, 24'd0, 32'd0);
            tick();
            for (int d = 0; d < 3; d++) begin
                int lat;
                int idx;
                lat = (d == 0) ? 1 : ((d == 1) ? 2 : 4);
                idx = m - lat + 1;
                if (idx >= 0 && idx < NB2B) begin
                    checkOutput($sformatf("b2b L%0d rready e%0d", lat, m), 64'(rreadyA[d]), 64'd1);
                    checkOutput($sformatf("b2b L%0d raddr e%0d", lat, m), 64'(raddrA[d]), 64'(expAddr[idx]));
                    checkOutput($sformatf("b2b L%0d rdata e%0d", lat, m), 64'(rdataA[d]), 64'(expData[idx]));
                end else begin
                    checkOutput($sformatf("b2b L%0d idle e%0d", lat, m), 64'(rreadyA[d]), 64'd0);
                end
            end
        end

        applyStimulus(1'b1, 8'd1, 24'd1, 32'h00000077);
        tick();
        applyStimulus(1'b1, 8'd0, 24'd1, 32'h0);
        tick();
        applyStimulus(1'b0, 8'd0, 24'd0, 32'd0);
        rstn = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("flush rready d%0d", d), 64'(rreadyA[d]), 64'd0);
            checkOutput($sformatf("flush cfg_q d%0d", d), 64'(cfgA[d] != '0), 64'd0);
        end
        tick();
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int d = 0; d < 3; d++)
                checkOutput($sformatf("flush quiet c%0d d%0d", c, d), 64'(rreadyA[d]), 64'd0);
        end
        checkOutput("flush cfg1", 64'(cfgA[2][1*DW +: DW]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lb_regbank.md
# lb_regbank

Parametrised local-bus register bank: the next generation of the hand-written localbus register map. It decodes localbus write/read commands against a contiguous window of NRW read-write configuration registers and NRO read-only status registers, and returns every transaction on the read side through an aligned, fixed-latency pipeline. It sits between the host-facing localbus bridge and the DSP/config fabric, replacing per-design `casex` decode with a generic, depth- and latency-configurable bank.

## Interface
- LBCWIDTH, 8, command field width
- LBAWIDTH, 24, address width
- LBDWIDTH, 32, data width
- WRITECMD, 1, wctrl value meaning write
- READCMD, 0, wctrl value meaning read
- NRW, 16, number of read-write registers (1..256)
- NRO, 8, number of read-only status registers (0..256)
- BASE, 0, first address of the window
- RDLAT, 2, response latency in clocks (1..4)
- DEFAULT_RDATA, 32'hdeadbeef, read data for unmapped reads

- clk  in  1  localbus clock
- rstn  in  1  asynchronous active-low reset
- wvalid  in  1  request valid, one transaction per cycle
- wctrl  in  LBCWIDTH  request command
- waddr  in  LBAWIDTH  request address
- wdata  in  LBDWIDTH  request write data
- rready  out  1  response valid, 1-cycle pulse per transaction
- rctrl  out  LBCWIDTH  echoed command
- raddr  out  LBAWIDTH  echoed address
- rdata  out  LBDWIDTH  read data, or echoed wdata for non-read
- cfg_q  out  NRW*LBDWIDTH  register contents, reg i at [i*LBDWIDTH +: LBDWIDTH]
- cfg_stb  out  NRW  1-cycle write strobe per RW register
- sts_i  in  NRO*LBDWIDTH  status inputs, same packing
- sts_rd_stb  out  NRO  1-cycle read strobe per RO register (clear-on-read sources)
- err_cnt  out  16  unmapped-access counter (only with LB_REGBANK_ERRCNT_EN)

## Operation
- Map: BASE+i → RW reg i (i<NRW); BASE+NRW+j → RO reg j (j<NRO); all else unmapped.
- Request accepted at every rising edge with wvalid=1; no backpressure.
- Write (wctrl==WRITECMD) hitting RW i: cfg_q[i]←wdata, cfg_stb[i]=1 for one cycle. Writes to RO or unmapped: no state change.
- Read (wctrl==READCMD): RW i returns cfg_q[i]; RO j returns sts_i[j] sampled at the accepting edge, sts_rd_stb[j]=1 for one cycle; unmapped returns DEFAULT_RDATA.
- Any other wctrl: no effect, rdata echoes wdata.
- Response: rctrl/raddr/rdata/rready carried together through an RDLAT-deep shift pipeline; write responses echo wdata.
- Read issued the cycle after a write to the same register returns the new value.
- Reset: cfg_q=0, cfg_stb=0, sts_rd_stb=0, rready=0, rctrl/raddr/rdata=0, err_cnt=0; in-flight responses discarded.

## Timing
- Request sampled at edge k → cfg_q/cfg_stb/sts_rd_stb change at edge k (visible cycle k+1).
- rready high in the cycle following edge k+RDLAT-1 (exactly RDLAT edges after acceptance), aligned with rctrl/raddr/rdata.
- Back-to-back requests yield back-to-back rready pulses in order, no gaps, no drops.
- rstn assertion takes effect immediately (async); deassertion released synchronously to clk upstream; first request accepted at the first edge with rstn=1.

## Configuration
- LB_REGBANK_ERRCNT_EN defined: err_cnt counts every unmapped access and every write to an RO register, saturating at 16'hffff; address BASE+NRW+NRO maps to err_cnt (read returns zero-extended count; any write clears it to 0, and a clear takes priority over a same-cycle increment).
- Undefined: err_cnt port and counter absent; BASE+NRW+NRO is unmapped.

## Test plan
- Reset then write 32'h12345678 to BASE+3 → cfg_stb[3] single pulse, cfg_q[3]=32'h12345678, rready after RDLAT with rdata=32'h12345678.
- Write BASE+5=32'hA5A5A5A5 then read BASE+5 next cycle → read response rdata=32'hA5A5A5A5, two consecutive rready pulses.
- Drive sts_i[2]=32'hCAFE0002, read BASE+NRW+2 → rdata=32'hCAFE0002, sts_rd_stb[2] single pulse.
- Read BASE+NRW+NRO+1 → rdata=32'hdeadbeef, no strobes; with ERRCNT_EN err_cnt=1, then write BASE+NRW+NRO → err_cnt=0.
- 20 back-to-back mixed reads/writes, RDLAT=1 and 4 → 20 in-order responses, raddr matching request order.
- Assert rstn low with 2 responses in flight → rready never pulses for them, all cfg_q=0.
